// File: rtl/draw_scheduler.sv
// Per-frame sequencer for the erase, wall and bird draw engines. It owns the single VGA plot port
// and handles game pacing, collision-driven game over, restart, and overrun/timeout monitoring.
module draw_scheduler #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int UPD_DIV = 4,
  parameter int TIMEOUT = 16383
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           go,
  input  logic           collision,
  input  logic           er_done,
  input  logic           wl_done,
  input  logic           bd_done,
  input  logic [X_W-1:0] er_x,
  input  logic [Y_W-1:0] er_y,
  input  logic [C_W-1:0] er_colour,
  input  logic           er_plot,
  input  logic [X_W-1:0] wl_x,
  input  logic [Y_W-1:0] wl_y,
  input  logic [C_W-1:0] wl_colour,
  input  logic           wl_plot,
  input  logic [X_W-1:0] bd_x,
  input  logic [Y_W-1:0] bd_y,
  input  logic [C_W-1:0] bd_colour,
  input  logic           bd_plot,
  output logic           er_start,
  output logic           wl_start,
  output logic           bd_start,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           update_en,
  output logic           restart,
  output logic           game_over,
  output logic           overrun,
  output logic           timeout_err,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_ERASE      = 3'd2,
    S_WALL       = 3'd3,
    S_BIRD       = 3'd4,
    S_UPDATE     = 3'd5,
    S_GAME_OVER  = 3'd6
  } state_t;

  localparam int FC_W = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic            entry_q;
  logic [WD_W-1:0] wd_cnt_q;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            pending_q, pending_d;
  logic            latch_q, latch_d;
  logic            restart_q, restart_d;
  logic            overrun_q, overrun_d;
  logic            terr_q, terr_d;

  logic            in_engine;
  logic            in_frame;
  logic            wd_hit;
  logic            eng_done;
  logic            owner_done;
  logic            coll_now;
  logic            frame_wrap;

  assign in_engine  = (state_q == S_ERASE) || (state_q == S_WALL) || (state_q == S_BIRD);
  assign in_frame   = in_engine || (state_q == S_UPDATE);
  assign wd_hit     = in_engine && (wd_cnt_q == WD_W'(TIMEOUT - 1));
  assign coll_now   = (state_q == S_BIRD) && collision && bd_plot;
  assign frame_wrap = (frame_cnt_q == FC_W'(UPD_DIV - 1));

  always_comb begin
    eng_done = 1'b0;
    unique case (state_q)
      S_ERASE: eng_done = er_done;
      S_WALL:  eng_done = wl_done;
      S_BIRD:  eng_done = bd_done;
      default: eng_done = 1'b0;
    endcase
  end

  // A done coinciding with the start pulse belongs to a previous run, so it is dropped.
  assign owner_done = (eng_done && !entry_q) || wd_hit;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    latch_d     = latch_q;
    frame_cnt_d = frame_cnt_q;
    restart_d   = 1'b0;
    overrun_d   = overrun_q;
    terr_d      = terr_q;

    if (coll_now) latch_d = 1'b1;
    if (wd_hit)   terr_d  = 1'b1;
    if (frame_tick && in_frame) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          restart_d = 1'b1;
          state_d   = S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        if (frame_tick || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_ERASE;
        end
      end
      S_ERASE: if (owner_done) state_d = S_WALL;
      S_WALL:  if (owner_done) state_d = S_BIRD;
      S_BIRD: begin
        // Include a collision seen in the done cycle itself.
        if (owner_done) state_d = (latch_q || coll_now) ? S_GAME_OVER : S_UPDATE;
      end
      S_UPDATE: begin
        frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + FC_W'(1);
        state_d     = S_WAIT_FRAME;
      end
      S_GAME_OVER: begin
        if (go) begin
          restart_d   = 1'b1;
          latch_d     = 1'b0;
          frame_cnt_d = '0;
          state_d     = S_WAIT_FRAME;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      entry_q     <= 1'b0;
      wd_cnt_q    <= '0;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      latch_q     <= 1'b0;
      restart_q   <= 1'b0;
      overrun_q   <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= (state_d != state_q);
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      latch_q     <= latch_d;
      restart_q   <= restart_d;
      overrun_q   <= overrun_d;
      terr_q      <= terr_d;
      if (state_d != state_q) wd_cnt_q <= '0;
      else if (in_engine)     wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  // Pixel port mux: zero latency, idle states drive an all-zero, non-plotting pixel.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    unique case (state_q)
      S_ERASE: begin
        vga_x = er_x; vga_y = er_y; vga_colour = er_colour; vga_plot = er_plot;
      end
      S_WALL: begin
        vga_x = wl_x; vga_y = wl_y; vga_colour = wl_colour; vga_plot = wl_plot;
      end
      S_BIRD: begin
        vga_x = bd_x; vga_y = bd_y; vga_colour = bd_colour; vga_plot = bd_plot;
      end
      default: begin
        vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
      end
    endcase
  end

  assign er_start    = entry_q && (state_q == S_ERASE);
  assign wl_start    = entry_q && (state_q == S_WALL);
  assign bd_start    = entry_q && (state_q == S_BIRD);
  assign update_en   = (state_q == S_UPDATE) && frame_wrap;
  assign restart     = restart_q;
  assign game_over   = (state_q == S_GAME_OVER);
  assign overrun     = overrun_q;
  assign timeout_err = terr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed frames plus randomized traffic, checked every cycle
// against a behavioural frame-sequencing model of the scheduler.
module tb_draw_scheduler;
  localparam int X_W = 8, Y_W = 7, C_W = 3, UD = 4, TO = 100;

  logic clk = 1'b0, reset = 1'b1;
  logic frame_tick = 0, go = 0, collision = 0;
  logic er_done = 0, wl_done = 0, bd_done = 0;
  logic [X_W-1:0] er_x = 0, wl_x = 0, bd_x = 0;
  logic [Y_W-1:0] er_y = 0, wl_y = 0, bd_y = 0;
  logic [C_W-1:0] er_colour = 0, wl_colour = 0, bd_colour = 0;
  logic er_plot = 0, wl_plot = 0, bd_plot = 0;
  logic er_start, wl_start, bd_start;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic vga_plot, update_en, restart, game_over, overrun, timeout_err;
  logic [2:0] state;

  draw_scheduler #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .UPD_DIV(UD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .go(go), .collision(collision),
    .er_done(er_done), .wl_done(wl_done), .bd_done(bd_done),
    .er_x(er_x), .er_y(er_y), .er_colour(er_colour), .er_plot(er_plot),
    .wl_x(wl_x), .wl_y(wl_y), .wl_colour(wl_colour), .wl_plot(wl_plot),
    .bd_x(bd_x), .bd_y(bd_y), .bd_colour(bd_colour), .bd_plot(bd_plot),
    .er_start(er_start), .wl_start(wl_start), .bd_start(bd_start),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .update_en(update_en), .restart(restart), .game_over(game_over),
    .overrun(overrun), .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int done_at[3];
  int dly_fix[3];
  bit en_done[3];
  bit rnd_dly = 0, spur = 0;
  bit f_go = 0, f_tick = 0, f_tick_wall = 0, f_coll_bird = 0, f_bdplot = 0;
  int r_tick = 0, r_go = 0, r_coll = 0;

  // Model: phase uses the documented state numbering; cin counts cycles since phase entry.
  int m_phase = 0, m_cin = 0, m_frames = 0;
  bit m_pending = 0, m_latch = 0, m_over = 0, m_terr = 0, m_restart = 0;

  int obs_er = 0, obs_wl = 0, obs_bd = 0, n_upd = 0, n_wall = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cin = 0; m_frames = 0;
    m_pending = 0; m_latch = 0; m_over = 0; m_terr = 0; m_restart = 0;
    for (int e = 0; e < 3; e++) done_at[e] = -1;
  endtask

  // One clock cycle: drive inputs, compare every output, advance the model, cross the edge.
  task automatic step();
    logic [2:0] dn;
    int ph, nph, exp_x, exp_y, exp_c, exp_p;
    bit od, nrst;
    ph = m_phase;
    er_x = X_W'($urandom); wl_x = X_W'($urandom); bd_x = X_W'($urandom);
    er_y = Y_W'($urandom); wl_y = Y_W'($urandom); bd_y = Y_W'($urandom);
    er_colour = C_W'($urandom); wl_colour = C_W'($urandom); bd_colour = C_W'($urandom);
    er_plot = 1'($urandom); wl_plot = 1'($urandom); bd_plot = 1'($urandom);
    if (f_bdplot) bd_plot = 1'b1;
    go = f_go || (r_go > 0 && $urandom_range(0, 99) < r_go);
    frame_tick = f_tick || (r_tick > 0 && $urandom_range(0, 99) < r_tick);
    if (f_tick_wall && ph == 3 && m_cin == 5) begin frame_tick = 1'b1; f_tick_wall = 0; end
    collision = (r_coll > 0 && $urandom_range(0, 999) < r_coll);
    if (f_coll_bird && ph == 4 && m_cin == 3) begin
      collision = 1'b1; bd_plot = 1'b1; f_coll_bird = 0;
    end
    f_go = 0; f_tick = 0;
    for (int e = 0; e < 3; e++) begin
      dn[e] = (done_at[e] >= 0 && cyc == done_at[e]);
      if (spur && (ph - 2) != e && $urandom_range(0, 31) == 0) dn[e] = 1'b1;
      if (spur && (ph - 2) == e && m_cin == 0 && $urandom_range(0, 3) == 0) dn[e] = 1'b1;
    end
    er_done = dn[0]; wl_done = dn[1]; bd_done = dn[2];
    #1;
    exp_x = 0; exp_y = 0; exp_c = 0; exp_p = 0;
    if (ph == 2) begin exp_x = er_x; exp_y = er_y; exp_c = er_colour; exp_p = er_plot; end
    if (ph == 3) begin exp_x = wl_x; exp_y = wl_y; exp_c = wl_colour; exp_p = wl_plot; end
    if (ph == 4) begin exp_x = bd_x; exp_y = bd_y; exp_c = bd_colour; exp_p = bd_plot; end
    chk("state", int'(state), ph);
    chk("er_start", int'(er_start), int'(ph == 2 && m_cin == 0));
    chk("wl_start", int'(wl_start), int'(ph == 3 && m_cin == 0));
    chk("bd_start", int'(bd_start), int'(ph == 4 && m_cin == 0));
    chk("vga_x", int'(vga_x), exp_x);
    chk("vga_y", int'(vga_y), exp_y);
    chk("vga_colour", int'(vga_colour), exp_c);
    chk("vga_plot", int'(vga_plot), exp_p);
    chk("update_en", int'(update_en), int'(ph == 5 && ((m_frames + 1) % UD) == 0));
    chk("restart", int'(restart), int'(m_restart));
    chk("game_over", int'(game_over), int'(ph == 6));
    chk("overrun", int'(overrun), int'(m_over));
    chk("timeout_err", int'(timeout_err), int'(m_terr));
    if (er_start) obs_er = cyc;
    if (wl_start) obs_wl = cyc;
    if (bd_start) obs_bd = cyc;
    if (update_en) n_upd++;
    if (state == 3'd3) n_wall++;

    if (ph >= 2 && ph <= 4 && m_cin == 0) begin
      done_at[ph - 2] = cyc + (rnd_dly ? int'($urandom_range(1, 40)) : dly_fix[ph - 2]);
      if (!en_done[ph - 2] || (rnd_dly && $urandom_range(0, 19) == 0)) done_at[ph - 2] = -1;
    end
    nph = ph; nrst = 0; od = 0;
    if (ph >= 2 && ph <= 4) begin
      od = (dn[ph - 2] && m_cin > 0) || (m_cin == TO - 1);
      if (m_cin == TO - 1) m_terr = 1;
    end
    if (ph == 4 && collision && bd_plot) m_latch = 1;
    case (ph)
      0: if (go) begin nph = 1; nrst = 1; end
      1: if (frame_tick || m_pending) begin nph = 2; m_pending = 0; end
      2: if (od) nph = 3;
      3: if (od) nph = 4;
      4: if (od) nph = m_latch ? 6 : 5;
      5: begin m_frames = (m_frames + 1) % UD; nph = 1; end
      6: if (go) begin nph = 1; nrst = 1; m_latch = 0; m_frames = 0; end
      default: nph = 0;
    endcase
    if (frame_tick && ph >= 2 && ph <= 5) begin m_pending = 1; m_over = 1; end
    m_cin = (nph != ph) ? 0 : m_cin + 1;
    m_phase = nph;
    m_restart = nrst;
    cyc++;
    @(posedge clk); #1;
  endtask

  // Run until the model is back waiting for a frame (or in game over), with a cycle budget.
  task automatic run_frame(input bit tick);
    int n;
    f_tick = tick;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_phase == 1 || m_phase == 6) && n < 2000);
    if (n >= 2000) chk("frame_budget", n, 0);
  endtask

  initial begin
    int n;
    model_reset();
    for (int e = 0; e < 3; e++) en_done[e] = 1;
    dly_fix[0] = 10; dly_fix[1] = 20; dly_fix[2] = 30;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'({er_start, wl_start, bd_start, vga_plot, update_en, restart,
                          game_over, overrun, timeout_err}), 0);
    reset = 1'b0;
    step();
    f_go = 1; step();
    chk("go_restart", int'(restart), 1);
    chk("go_state", int'(state), 1);

    // Four frames with fixed engine latencies; only the fourth produces update_en.
    for (int f = 1; f <= 4; f++) begin
      run_frame(1);
      if (f == 1) begin
        chk("er_to_wl", obs_wl - obs_er, 11);
        chk("wl_to_bd", obs_bd - obs_wl, 21);
      end
      if (f == 3) chk("upd_before4", n_upd, 0);
      step();
    end
    chk("upd_on4", n_upd, 1);

    // Frame tick during WALL: overrun, and the next erase starts without a fresh tick.
    f_tick_wall = 1;
    run_frame(1);
    chk("overrun_set", int'(overrun), 1);
    step();
    chk("pending_erase", int'(state), 2);
    run_frame(0);

    // Wall engine never finishes: watchdog releases it after TO cycles.
    en_done[1] = 0; n_wall = 0;
    run_frame(1);
    chk("wall_cycles", n_wall, TO);
    chk("timeout_flag", int'(timeout_err), 1);
    en_done[1] = 1;

    // Single colliding bird pixel leads to game over, then go restarts.
    f_coll_bird = 1;
    run_frame(1);
    chk("gameover_state", int'(state), 6);
    chk("gameover_flag", int'(game_over), 1);
    step();
    f_go = 1; step();
    chk("restart_pulse", int'(restart), 1);
    chk("restart_state", int'(state), 1);

    // Asynchronous reset in the middle of BIRD.
    f_tick = 1; n = 0;
    do begin step(); n++; end while (!(m_phase == 4 && m_cin == 3) && n < 500);
    f_bdplot = 1;
    bd_plot = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_plot", int'(vga_plot), 0);
    chk("mid_rst_outs", int'({er_start, wl_start, bd_start, vga_x, update_en, restart,
                              game_over, overrun, timeout_err}), 0);
    f_bdplot = 0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    f_go = 1; step();

    // Randomized traffic: random latencies, stray dones, overruns, collisions and restarts.
    rnd_dly = 1; spur = 1; r_tick = 2; r_go = 5; r_coll = 20;
    for (int i = 0; i < 6000; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
